// File: rtl/edge_grant_pkg.sv
// Shared constants and helpers for the edge-triggered grant arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: edge-type encodings and the grant index width function.
package edge_grant_pkg;

  localparam int EDGE_NEG  = 0;
  localparam int EDGE_POS  = 1;
  localparam int EDGE_BOTH = 2;

  // Index width for n channels; a single channel still needs a 1-bit index.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/edge_grant_arbiter_if.sv
// Handshake bundle between the edge arbiter and its consumer.
// Latency: n/a (wires only).
// Backpressure: gnt_rdy from the consumer stalls gnt_vld/gnt_idx.
// Signals: din (channel levels), gnt_rdy, clr_ovf in; gnt_vld, gnt_idx,
//          pend_out, ovf_out out. slave = arbiter side, master = consumer side.
interface edge_grant_arbiter_if
  import edge_grant_pkg::*;
#(
  parameter int MAX_DESC = 16
) ();

  localparam int IW = idx_w(MAX_DESC);

  logic [MAX_DESC-1:0] din;
  logic                gnt_rdy;
  logic                clr_ovf;
  logic                gnt_vld;
  logic [IW-1:0]       gnt_idx;
  logic [MAX_DESC-1:0] pend_out;
  logic [MAX_DESC-1:0] ovf_out;

  modport slave (
    input  din, gnt_rdy, clr_ovf,
    output gnt_vld, gnt_idx, pend_out, ovf_out
  );

  modport master (
    output din, gnt_rdy, clr_ovf,
    input  gnt_vld, gnt_idx, pend_out, ovf_out
  );

endinterface

// File: rtl/grant_pick.sv
// Picks one pending channel: lowest index, or round-robin after ptr when
// EDGE_GRANT_RR_EN is defined.
// Latency: purely combinational. Backpressure: none (no state).
// Ports: pend (pending vector), ptr (last loaded index) in;
//        sel_oh (one-hot pick, zero if nothing pending), sel_idx out.
module grant_pick #(
  parameter int N  = 16,
  parameter int IW = 4
) (
  input  logic [N-1:0]  pend,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  sel_oh,
  output logic [IW-1:0] sel_idx
);

`ifndef EDGE_GRANT_RR_EN
  // Fixed priority never looks at the pointer.
  logic unused_ptr;
  assign unused_ptr = ^ptr;
`endif

  logic found;

  always_comb begin
    sel_oh  = '0;
    sel_idx = '0;
    found   = 1'b0;
`ifdef EDGE_GRANT_RR_EN
    // First pass: channels strictly above the last loaded one.
    for (int i = 0; i < N; i++) begin
      if (!found && pend[i] && (IW'(i) > ptr)) begin
        found     = 1'b1;
        sel_oh[i] = 1'b1;
        sel_idx   = IW'(i);
      end
    end
`endif
    // Lowest pending index; in round-robin mode this is the wrap-around pass.
    for (int i = 0; i < N; i++) begin
      if (!found && pend[i]) begin
        found     = 1'b1;
        sel_oh[i] = 1'b1;
        sel_idx   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/edge_grant_arbiter.sv
// Captures per-channel edges into a pending vector and grants them one at a
// time. Latency: 1 cycle from pend rising to gnt_vld (free output register).
// Backpressure: gnt_rdy=0 holds gnt_vld/gnt_idx; new edges on a pending,
// unloaded channel set its sticky ovf bit.
// Ports: clk, rst_n (sync, active-low), bus (edge_grant_arbiter_if.slave).
// Build option: EDGE_GRANT_RR_EN selects round-robin instead of fixed priority.
module edge_grant_arbiter
  import edge_grant_pkg::*;
#(
  parameter int MAX_DESC = 16,
  parameter int EDGE_TYP = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  edge_grant_arbiter_if.slave bus
);

  localparam int IW = idx_w(MAX_DESC);

  logic [MAX_DESC-1:0] din_ff;
  logic [MAX_DESC-1:0] pend;
  logic [MAX_DESC-1:0] ovf;
  logic [MAX_DESC-1:0] evt;
  logic [MAX_DESC-1:0] sel_oh;
  logic [MAX_DESC-1:0] load_vec;
  logic [MAX_DESC-1:0] ovf_set;
  logic [IW-1:0]       sel_idx;
  logic [IW-1:0]       ptr;
  logic [IW-1:0]       gnt_idx_q;
  logic                gnt_vld_q;
  logic                reg_free;
  logic                load;

  always_comb begin
    case (EDGE_TYP)
      EDGE_NEG:  evt = din_ff & ~bus.din;
      EDGE_BOTH: evt = din_ff ^ bus.din;
      default:   evt = ~din_ff & bus.din;
    endcase
  end

  assign reg_free = !gnt_vld_q || bus.gnt_rdy;
  // Selection only ever sees registered pend, never this cycle's edges.
  assign load     = reg_free && (|pend);
  assign load_vec = load ? sel_oh : '0;
  // An edge on a channel that is being loaded re-arms it instead of overflowing.
  assign ovf_set  = evt & pend & ~load_vec;

`ifdef EDGE_GRANT_RR_EN
  logic [IW-1:0] rr_ptr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (load) begin
      rr_ptr <= sel_idx;
    end
  end

  assign ptr = rr_ptr;
`else
  assign ptr = '0;
`endif

  grant_pick #(
    .N  (MAX_DESC),
    .IW (IW)
  ) u_pick (
    .pend    (pend),
    .ptr     (ptr),
    .sel_oh  (sel_oh),
    .sel_idx (sel_idx)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      din_ff    <= '0;
      pend      <= '0;
      ovf       <= '0;
      gnt_vld_q <= 1'b0;
      gnt_idx_q <= '0;
    end else begin
      din_ff <= bus.din;
      pend   <= (pend & ~load_vec) | evt;
      // A fresh overflow beats a simultaneous clear.
      ovf    <= (ovf & ~{MAX_DESC{bus.clr_ovf}}) | ovf_set;
      if (reg_free) begin
        gnt_vld_q <= load;
        if (load) begin
          gnt_idx_q <= sel_idx;
        end
      end
    end
  end

  assign bus.gnt_vld  = gnt_vld_q;
  assign bus.gnt_idx  = gnt_idx_q;
  assign bus.pend_out = pend;
  assign bus.ovf_out  = ovf;

endmodule

// File: doc/edge_grant_arbiter.md
EDGE_GRANT_ARBITER -- requirements
Module: edge_grant_arbiter

Interface
REQ-001 SHALL have parameter MAX_DESC, default 16, number of monitored channels, legal 1..64.
REQ-002 SHALL have parameter EDGE_TYP, default 1, event type: 0 negedge, 1 posedge, 2 both edges.
REQ-003 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port din  input  MAX_DESC  per-channel level inputs, synchronous to clk.
REQ-006 SHALL have port gnt_rdy  input  1  consumer accepts current grant.
REQ-007 SHALL have port clr_ovf  input  1  clears all overflow flags.
REQ-008 SHALL have port gnt_vld  output  1  grant valid.
REQ-009 SHALL have port gnt_idx  output  IW  granted channel index; IW = max(1, clog2(MAX_DESC)).
REQ-010 SHALL have port pend_out  output  MAX_DESC  pending-event vector.
REQ-011 SHALL have port ovf_out  output  MAX_DESC  sticky per-channel overflow flags.

Function
REQ-012 SHALL register din into din_ff every cycle; event[i] = edge of selected polarity between din_ff[i] and din[i].
REQ-013 SHALL set pend[i] on the clk edge at which event[i] is true.
REQ-014 SHALL clear pend[i] on the clk edge at which channel i is loaded into the output register.
REQ-015 SHALL keep pend[i] set, with no overflow, when event[i] and the load of channel i occur on the same edge.
REQ-016 SHALL set ovf[i] when event[i] occurs while pend[i] is set and channel i is not loaded on that edge; the event is otherwise dropped.
REQ-017 SHALL clear all ovf bits on clr_ovf; a new overflow on the same edge SHALL win, leaving that bit set.
REQ-018 SHALL treat the output register as free when gnt_vld=0, or when gnt_vld=1 and gnt_rdy=1.
REQ-019 SHALL, when the output register is free and pend is nonzero, load one channel: gnt_vld<=1, gnt_idx<=selected index.
REQ-020 SHALL, when the output register is free and pend is zero, drive gnt_vld<=0; gnt_idx holds its value.
REQ-021 SHALL hold gnt_vld and gnt_idx stable while gnt_vld=1 and gnt_rdy=0.
REQ-022 SHALL sustain one grant per cycle under back-to-back acceptance, with no bubble.
REQ-023 SHALL have a latency of one cycle from pend[i] rising to gnt_vld, given a free output register and no higher-priority pending channel.
REQ-024 SHALL ignore gnt_rdy while gnt_vld=0.
REQ-025 SHALL compute the selection from pend as registered, never from same-cycle events.

Reset
REQ-026 SHALL, on rst_n=0, zero din_ff, pend, ovf, gnt_vld, gnt_idx and the round-robin pointer.
REQ-027 SHALL drop all pending events and any held grant when reset is asserted mid-operation; gnt_vld=0 after the reset edge.
REQ-028 SHALL report a din bit that is high at reset release as a posedge event (din_ff=0).

Configuration
REQ-029 SHALL support macro EDGE_GRANT_RR_EN.
REQ-030 SHALL, with EDGE_GRANT_RR_EN defined, select round-robin: the search starts at last loaded index + 1 and wraps at MAX_DESC-1 to 0; the pointer updates only on load.
REQ-031 SHALL, without EDGE_GRANT_RR_EN, select fixed priority: the lowest pending index wins, and no pointer register is built.

Structure
REQ-032 SHALL place the EDGE_NEG/EDGE_POS/EDGE_BOTH constants and the index-width function in shared package edge_grant_pkg.
REQ-033 SHALL implement selection in one sub-module, grant_pick (pend, pointer in -> one-hot and index out, purely combinational).
REQ-034 SHALL support MAX_DESC=1, with gnt_idx fixed at 0 and width 1.

Verification
REQ-035 SHALL cover: EDGE_TYP=1, din 0x0000->0x0014, gnt_rdy=1 -> grants idx 2 then idx 4 on consecutive cycles; pend returns to 0.
REQ-036 SHALL cover: gnt_rdy=0 with grant idx 2 held 5 cycles while din[2] toggles 0->1->0->1 -> ovf_out[2]=1, gnt_idx stays 2; clr_ovf clears it.
REQ-037 SHALL cover: RR build, channels 0 and 5 re-triggered after every grant -> grants alternate 0,5,0,5; fixed build -> 0 repeats whenever pend[0] is set.
REQ-038 SHALL cover: EDGE_TYP=2, din[3] 0->1->0 two cycles apart -> two grants of idx 3, no overflow.
REQ-039 SHALL cover: rst_n low for one cycle with pend=0x00FF and gnt_vld=1 -> all outputs 0 next cycle; din held 0x0001 -> one grant of idx 0 after release.
REQ-040 SHALL cover: MAX_DESC=1 and MAX_DESC=64, event on the top channel -> gnt_idx = MAX_DESC-1.
